// File: rtl/rom_arb_pkg.sv
// Shared types and default parameters for the ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned DW_DEF    = 4;
  localparam int unsigned STEP_DEF  = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick_c,
  output logic [IW-1:0]   o_idx_c,
  output logic            o_any_c
);

  int unsigned w_slot;

  always_comb begin
    o_pick_c = '0;
    o_idx_c  = '0;
    o_any_c  = 1'b0;
    w_slot   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_slot = (32'(i_ptr) + off) % NREQ;
      if (!o_any_c && i_req[w_slot]) begin
        o_pick_c[w_slot] = 1'b1;
        o_idx_c          = IW'(w_slot);
        o_any_c          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter in front of a self-initialising lookup table; one read per cycle.
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned STEP  = STEP_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reinit,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               init_done
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic            r_rsp_valid;
  logic [IW-1:0]   r_rsp_id;
  logic [DW-1:0]   r_rsp_data;
  logic            r_init_done;
  logic            w_init_done_nxt;
  logic            w_tbl_we;
  logic            w_grant_en;
  logic            w_last;
  logic [NREQ-1:0] w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_rd_data;
  logic [DW-1:0]   w_init_val;

  logic [DW-1:0]   r_table [DEPTH];

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_pick_c (w_pick),
    .o_idx_c  (w_idx),
    .o_any_c  (w_any)
  );

  assign w_last     = (r_cnt == AW'(DEPTH - 1));
  assign w_init_val = DW'(32'(r_cnt) * STEP);
  assign w_sel_addr = addr[32'(w_idx)*AW +: AW];

  // Addresses beyond the populated range read as zero.
  always_comb begin
    w_rd_data = '0;
    if (32'(w_sel_addr) < DEPTH) w_rd_data = r_table[w_sel_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_last) w_state_nxt = RUN;
      RUN:     if (reinit) w_state_nxt = INIT;
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    w_tbl_we        = 1'b0;
    w_grant_en      = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_init_done_nxt = r_init_done;
    case (r_state)
      INIT: begin
        w_tbl_we  = 1'b1;
        w_cnt_nxt = w_last ? '0 : r_cnt + AW'(1);
        if (w_last) w_init_done_nxt = 1'b1;
      end
      RUN: begin
        if (reinit) begin
          w_cnt_nxt       = '0;
          w_init_done_nxt = 1'b0;
        end else begin
          w_grant_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Table storage carries no reset; contents are only valid once INIT completes.
  always_ff @(posedge clk) begin
    if (w_tbl_we) r_table[r_cnt] <= w_init_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_init_done <= w_init_done_nxt;
      r_gnt       <= w_grant_en ? w_pick : '0;
      r_rsp_valid <= w_grant_en & w_any;
      if (w_grant_en && w_any) begin
        r_rsp_id   <= w_idx;
        r_rsp_data <= w_rd_data;
        r_ptr      <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
      end
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign init_done = r_init_done;

endmodule

// File: doc/rom_rd_arbiter.md
ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 The block SHALL have parameter DEPTH, default 8: table entries.
REQ-003 The block SHALL have parameter DW, default 4: data width.
REQ-004 The block SHALL have parameter STEP, default 2: init increment between entries.
REQ-005 The block SHALL have derived constant AW = clog2(DEPTH), default 3, and IW = clog2(NREQ), default 2.
REQ-006 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port reinit, input, 1 bit: single-cycle request to rebuild the table.
REQ-009 The block SHALL have port req, input, NREQ bits: per-requester read request.
REQ-010 The block SHALL have port addr, input, NREQ*AW bits: packed addresses; requester i uses bits [i*AW +: AW].
REQ-011 The block SHALL have port gnt, output, NREQ bits: one-hot grant pulse.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: read data valid.
REQ-013 The block SHALL have port rsp_id, output, IW bits: index of the requester the response belongs to.
REQ-014 The block SHALL have port rsp_data, output, DW bits: table contents.
REQ-015 The block SHALL have port init_done, output, 1 bit: high while the table is valid and grants are possible.

Function
REQ-016 The table SHALL be internal storage of DEPTH x DW bits, written only by the init sequence, with entry k = (k*STEP) mod 2^DW (defaults: 0,2,4,...,14).
REQ-017 The state machine SHALL have two states: INIT and RUN.
REQ-018 In INIT, entry cnt SHALL be written on each clk edge, then cnt increments; the edge that writes entry DEPTH-1 SHALL move the state to RUN and set init_done=1, so INIT lasts exactly DEPTH cycles.
REQ-019 In INIT, gnt SHALL stay 0 and req SHALL be ignored.
REQ-020 In RUN, at most one grant SHALL be issued per cycle, combinationally from req and the round-robin pointer ptr: the first i with req[i]=1, scanning from ptr upward modulo NREQ.
REQ-021 gnt SHALL be a registered single-cycle pulse: a request seen at edge N produces gnt high during cycle N+1.
REQ-022 After a grant to requester i, ptr SHALL become (i+1) mod NREQ; with no grant, ptr SHALL hold.
REQ-023 Response SHALL appear on the same edge as gnt: rsp_valid=1, rsp_id=i, rsp_data=table[addr_i sampled at grant decision]; otherwise rsp_valid=0 and rsp_id/rsp_data hold their last values.
REQ-024 A requester SHALL hold req and addr until it sees gnt, and SHALL deassert req in the gnt cycle or be served again; withdrawing req before grant is legal.
REQ-025 A requester still asserting req in its gnt cycle SHALL NOT be re-granted in the next cycle while others request (pointer has advanced); if it is the sole requester, it SHALL be re-granted.
REQ-026 reinit=1 in RUN SHALL issue no grant that cycle, clear init_done and cnt, and enter INIT on the next edge; reinit in INIT SHALL be ignored.
REQ-027 An address >= DEPTH (non-power-of-2 DEPTH) SHALL return 0.

Reset
REQ-028 Asserting rst_n low SHALL immediately and asynchronously set state=INIT, cnt=0, ptr=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, init_done=0.
REQ-029 Table contents SHALL be undefined until rewritten by INIT, and reset SHALL abort any in-progress INIT or RUN activity.

Structure
REQ-030 Package rom_arb_pkg SHALL hold the state enum (INIT, RUN) and default parameter constants.
REQ-031 Round-robin selection SHALL be one sub-module, rr_pick (combinational: req, ptr -> one-hot pick, index, any); pointer, FSM and table SHALL stay in rom_rd_arbiter.

Verification
REQ-032 Release reset, no req -> init_done rises after exactly 8 edges; reads of addr 0..7 then return 0,2,4,6,8,10,12,14.
REQ-033 During INIT, assert req=4'b1111 -> gnt stays 0 until init_done=1; first grant goes to requester 0.
REQ-034 Hold req=4'b1111 with addr=i+1 for requester i -> grants cycle 0,1,2,3,0; rsp_data sequence is 2,4,6,8,2; rsp_id matches.
REQ-035 Only requester 2 holds req continuously -> gnt[2] every cycle; rsp_id=2.
REQ-036 Pulse reinit while req=4'b0011 -> no gnt in that cycle; gnt stays 0 for 8 cycles; service resumes at the stored ptr.
REQ-037 Drive rst_n low mid-burst -> gnt, rsp_valid and init_done drop without a clock edge; after release, INIT restarts from entry 0.
